// File: rtl/bp_trace_pkg.sv
// Shared types and default widths for the commit-trace branch encoder.
package bp_trace_pkg;

  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_STEP_BYTES  = 4;
  localparam int unsigned DEF_SYNC_PERIOD = 255;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  // Width of the fields carried by the commit stage; the encoder traces the low PC_W bits.
  localparam int unsigned COMMIT_PC_W    = 64;
  localparam int unsigned COMMIT_INSTR_W = 32;

  typedef enum logic [1:0] {
    TT_BRANCH   = 2'b00,
    TT_SYNC     = 2'b01,
    TT_OVERFLOW = 2'b10,
    TT_START    = 2'b11
  } trace_type_e;

  typedef enum logic {
    TRK_IDLE  = 1'b0,
    TRK_TRACK = 1'b1
  } trk_state_e;

  typedef struct packed {
    logic [COMMIT_PC_W-1:0]    pc;
    logic [COMMIT_INSTR_W-1:0] instr;
  } bp_commit_pkt_s;

endpackage

// File: rtl/bp_trace_branch_encoder_fifo.sv
// Synchronous packet FIFO between the encoder and the trace sink.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module bp_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign valid_o = !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while empty since data_o is gated.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_trace_branch_encoder.sv
// Commit-trace encoder: turns the committed-PC stream into START/BRANCH/SYNC/OVERFLOW
// packets and queues them for the trace sink.
module bp_trace_branch_encoder
  import bp_trace_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STEP_BYTES  = DEF_STEP_BYTES,
  parameter int unsigned SYNC_PERIOD = DEF_SYNC_PERIOD,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int unsigned PKT_W      = 2 + CNT_W + PC_W
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  bp_commit_pkt_s   commit_pkt_i,
  input  logic             commit_valid_i,
  output logic [PKT_W-1:0] trace_data_o,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic             overflow_o
);

  trk_state_e       state_q, state_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic             drop_pending_q, drop_pending_d;

  logic             commit_c;
  logic [PC_W-1:0]  pc_c;
  logic             seq_c, sync_hit_c;
  logic [CNT_W-1:0] run_inc_c, skip_inc_c;
  logic             fifo_full, fifo_empty, pop_c, can_push_c;
  logic             trk_gen_c, ovf_gen_c, drop_c, push_c;
  logic [PKT_W-1:0] pkt_c;
  logic             unused_commit;

  assign unused_commit = ^commit_pkt_i;

  assign commit_c   = commit_valid_i && enable_i;
  assign pc_c       = commit_pkt_i.pc[PC_W-1:0];
  assign seq_c      = (pc_c == last_pc_q + PC_W'(STEP_BYTES));
  assign run_inc_c  = run_cnt_q + CNT_W'(1);
  assign sync_hit_c = (run_inc_c == CNT_W'(SYNC_PERIOD));
  assign skip_inc_c = (&skip_cnt_q) ? skip_cnt_q : skip_cnt_q + CNT_W'(1);

  // A full FIFO still takes a push when the sink pops the head this cycle.
  assign pop_c      = trace_valid_o && trace_ready_i;
  assign can_push_c = !fifo_full || pop_c;

  // Tracker state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= TRK_IDLE;
    else            state_q <= state_d;
  end

  // Tracker next state: disable or a dropped packet sends us back to IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable_i || drop_c) begin
      state_d = TRK_IDLE;
    end else if (state_q == TRK_IDLE && !drop_pending_q && commit_c) begin
      state_d = TRK_TRACK;
    end
  end

  // Packet generation for the current cycle.
  always_comb begin
    trk_gen_c = 1'b0;
    ovf_gen_c = 1'b0;
    pkt_c     = '0;
    case (state_q)
      TRK_IDLE: begin
        if (drop_pending_q) begin
          // A commit in the flush cycle is folded into the reported skip count.
          ovf_gen_c = 1'b1;
          pkt_c     = {TT_OVERFLOW, (commit_c ? skip_inc_c : skip_cnt_q), last_pc_q};
        end else if (commit_c) begin
          trk_gen_c = 1'b1;
          pkt_c     = {TT_START, CNT_W'(0), pc_c};
        end
      end
      TRK_TRACK: begin
        if (commit_c) begin
          if (!seq_c) begin
            trk_gen_c = 1'b1;
            pkt_c     = {TT_BRANCH, run_cnt_q, pc_c};
          end else if (sync_hit_c) begin
            trk_gen_c = 1'b1;
            pkt_c     = {TT_SYNC, CNT_W'(SYNC_PERIOD), pc_c};
          end
        end
      end
      default: ;
    endcase
  end

  // A pending OVERFLOW just waits for space; only tracked packets can be dropped.
  assign drop_c     = trk_gen_c && !can_push_c;
  assign push_c     = (trk_gen_c || ovf_gen_c) && can_push_c;
  assign overflow_o = drop_c;

  // Counter, last-PC and drop bookkeeping.
  always_comb begin
    last_pc_d      = last_pc_q;
    run_cnt_d      = run_cnt_q;
    skip_cnt_d     = skip_cnt_q;
    drop_pending_d = drop_pending_q;

    // last_pc tracks the last traced commit so OVERFLOW reports where tracing stopped.
    if (commit_c && !drop_pending_q && !drop_c) last_pc_d = pc_c;

    if (commit_c && state_q == TRK_TRACK && seq_c && !sync_hit_c) begin
      run_cnt_d = run_inc_c;
    end else if (commit_c && !drop_pending_q) begin
      run_cnt_d = '0;
    end
    if (!enable_i) run_cnt_d = '0;

    if (drop_c) begin
      drop_pending_d = 1'b1;
      skip_cnt_d     = CNT_W'(1);
    end else if (ovf_gen_c) begin
      if (can_push_c) begin
        drop_pending_d = 1'b0;
        skip_cnt_d     = '0;
      end else if (commit_c) begin
        skip_cnt_d = skip_inc_c;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_pc_q      <= '0;
      run_cnt_q      <= '0;
      skip_cnt_q     <= '0;
      drop_pending_q <= 1'b0;
    end else begin
      last_pc_q      <= last_pc_d;
      run_cnt_q      <= run_cnt_d;
      skip_cnt_q     <= skip_cnt_d;
      drop_pending_q <= drop_pending_d;
    end
  end

  bp_trace_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push_c),
    .data_i    (pkt_c),
    .pop_i     (pop_c),
    .data_o    (trace_data_o),
    .valid_o   (trace_valid_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_bp_trace_branch_encoder.sv
// Self-checking bench for bp_trace_branch_encoder with a queue-based reference model.
module tb_bp_trace_branch_encoder;
  import bp_trace_pkg::*;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned STEP_BYTES  = 4;
  localparam int unsigned SYNC_PERIOD = 4;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned PKT_W       = 2 + CNT_W + PC_W;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic             enable_i = 1'b0;
  bp_commit_pkt_s   commit_pkt_i = '0;
  logic             commit_valid_i = 1'b0;
  logic [PKT_W-1:0] trace_data_o;
  logic             trace_valid_o;
  logic             trace_ready_i = 1'b0;
  logic             overflow_o;

  bp_trace_branch_encoder #(
    .PC_W        (PC_W),
    .CNT_W       (CNT_W),
    .STEP_BYTES  (STEP_BYTES),
    .SYNC_PERIOD (SYNC_PERIOD),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .commit_pkt_i   (commit_pkt_i),
    .commit_valid_i (commit_valid_i),
    .trace_data_o   (trace_data_o),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a packet queue standing in for the FIFO plus the tracker variables.
  logic [PKT_W-1:0] mdl_q[$];
  bit               mdl_track, mdl_pend;
  logic [31:0]      mdl_last;
  int               mdl_run, mdl_skip;

  logic [PKT_W-1:0] obs_q[$];
  logic [PKT_W-1:0] exp_q[$];
  int               cyc_mis, ovf_seen, cycle;
  bit               last_ovf;
  string            mis_msg;

  int checks = 0;
  int errors = 0;

  function automatic logic [PKT_W-1:0] pk(input logic [1:0] t, input int c, input logic [31:0] pc);
    return {t, 8'(c), pc};
  endfunction

  task automatic mdl_clear();
    mdl_q.delete(); obs_q.delete(); exp_q.delete();
    mdl_track = 0; mdl_pend = 0; mdl_last = '0; mdl_run = 0; mdl_skip = 0;
    cyc_mis = 0; ovf_seen = 0; last_ovf = 0; mis_msg = "";
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; enable_i = 1'b0; commit_valid_i = 1'b0;
    trace_ready_i = 1'b0; commit_pkt_i = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    mdl_clear();
  endtask

  // One clock: drive, compare against model at the falling edge, advance model.
  task automatic step(input bit en, input bit v, input logic [63:0] pc, input bit rdy);
    bit               pop, can_push, acc, gen, exp_ovf, exp_valid;
    logic [PKT_W-1:0] pkt, exp_head;
    logic [31:0]      p;
    int               skip_e;
    enable_i = en; commit_valid_i = v; trace_ready_i = rdy;
    commit_pkt_i.pc = pc; commit_pkt_i.instr = $urandom();
    @(negedge clk_i);
    p         = pc[31:0];
    acc       = en && v;
    exp_valid = (mdl_q.size() != 0);
    exp_head  = exp_valid ? mdl_q[0] : '0;
    pop       = exp_valid && rdy;
    can_push  = (mdl_q.size() < FIFO_DEPTH) || pop;
    gen = 0; exp_ovf = 0; pkt = '0;
    if (pop) exp_q.push_back(mdl_q.pop_front());
    if (mdl_pend) begin
      skip_e = acc ? ((mdl_skip < 255) ? mdl_skip + 1 : 255) : mdl_skip;
      if (can_push) begin
        mdl_q.push_back(pk(TT_OVERFLOW, skip_e, mdl_last));
        mdl_pend = 0; mdl_skip = 0;
      end else begin
        mdl_skip = skip_e;
      end
    end else if (acc) begin
      if (!mdl_track) begin
        gen = 1; pkt = pk(TT_START, 0, p);
      end else if (p != mdl_last + 32'(STEP_BYTES)) begin
        gen = 1; pkt = pk(TT_BRANCH, mdl_run, p);
      end else if (mdl_run + 1 == SYNC_PERIOD) begin
        gen = 1; pkt = pk(TT_SYNC, int'(SYNC_PERIOD), p);
      end
      if (!gen) begin
        mdl_run++; mdl_last = p;
      end else if (can_push) begin
        mdl_q.push_back(pkt); mdl_track = 1; mdl_run = 0; mdl_last = p;
      end else begin
        exp_ovf = 1; mdl_pend = 1; mdl_skip = 1; mdl_track = 0; mdl_run = 0;
      end
    end
    if (!en) begin mdl_track = 0; mdl_run = 0; end

    last_ovf = overflow_o;
    if (overflow_o === 1'b1) ovf_seen++;
    if (trace_valid_o === 1'b1 && rdy) obs_q.push_back(trace_data_o);
    if (trace_valid_o !== exp_valid || (exp_valid && trace_data_o !== exp_head) ||
        overflow_o !== exp_ovf) begin
      if (cyc_mis == 0)
        mis_msg = $sformatf("cycle %0d valid=%b(want %b) data=%h(want %h) ovf=%b(want %b)",
                            cycle, trace_valid_o, exp_valid, trace_data_o, exp_head,
                            overflow_o, exp_ovf);
      cyc_mis++;
    end
    @(posedge clk_i); #1;
    cycle++;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", trace_valid_o); end
    checks++;
    if (trace_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", trace_data_o); end
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [PKT_W-1:0] want[$];
    do_reset();
    step(1, 1, 64'h1000, 1);
    checks++;
    if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL basic_latency: valid=%b want 1", trace_valid_o); end
    step(1, 1, 64'h1004, 1);
    step(1, 1, 64'h2000, 1);
    step(1, 1, 64'h2004, 1);
    repeat (3) step(1, 0, 64'h0, 1);
    want.push_back(pk(TT_START, 0, 32'h1000));
    want.push_back(pk(TT_BRANCH, 1, 32'h2000));
    checks++;
    if (obs_q.size() != want.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL basic_pkt%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL basic_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  task automatic test_sync();
    logic [PKT_W-1:0] want[$];
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 64'h100 + 64'(4 * i), 1);
    repeat (3) step(1, 0, 64'h0, 1);
    want.push_back(pk(TT_START, 0, 32'h100));
    want.push_back(pk(TT_SYNC, 4, 32'h110));
    checks++;
    if (obs_q.size() != want.size()) begin errors++; $display("FAIL sync_count: got %0d want %0d", obs_q.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL sync_pkt%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL sync_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  task automatic test_wrap();
    logic [PKT_W-1:0] want[$];
    do_reset();
    step(1, 1, 64'hFFFF_FFFC, 1);
    step(1, 1, 64'h0000_0000, 1);
    step(1, 1, 64'h0000_5000, 1);
    repeat (3) step(1, 0, 64'h0, 1);
    want.push_back(pk(TT_START, 0, 32'hFFFF_FFFC));
    want.push_back(pk(TT_BRANCH, 1, 32'h5000));
    checks++;
    if (obs_q.size() != want.size()) begin errors++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL wrap_pkt%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL wrap_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  task automatic test_overflow();
    logic [PKT_W-1:0] want[$];
    do_reset();
    step(1, 1, 64'h1000, 0);
    step(1, 1, 64'h2000, 0);
    step(1, 1, 64'h3000, 0);
    step(1, 1, 64'h4000, 0);
    step(1, 1, 64'h5000, 0);
    checks++;
    if (last_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", last_ovf); end
    step(1, 1, 64'h6000, 0);
    checks++;
    if (last_ovf !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", last_ovf); end
    step(1, 1, 64'h7000, 0);
    step(1, 1, 64'h8000, 0);
    repeat (6) step(1, 0, 64'h0, 1);
    step(1, 1, 64'h9000, 1);
    repeat (3) step(1, 0, 64'h0, 1);
    want.push_back(pk(TT_START, 0, 32'h1000));
    want.push_back(pk(TT_BRANCH, 0, 32'h2000));
    want.push_back(pk(TT_BRANCH, 0, 32'h3000));
    want.push_back(pk(TT_BRANCH, 0, 32'h4000));
    want.push_back(pk(TT_OVERFLOW, 4, 32'h4000));
    want.push_back(pk(TT_START, 0, 32'h9000));
    checks++;
    if (obs_q.size() != want.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL ovf_pkt%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
    checks++;
    if (ovf_seen != 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf_seen); end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL ovf_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  task automatic test_enable();
    logic [PKT_W-1:0] want[$];
    do_reset();
    step(1, 1, 64'h1000, 1);
    step(1, 1, 64'h1004, 1);
    step(1, 1, 64'h1008, 1);
    step(0, 1, 64'h100C, 1);
    step(0, 1, 64'h1010, 1);
    step(1, 1, 64'h3000, 1);
    repeat (3) step(1, 0, 64'h0, 1);
    want.push_back(pk(TT_START, 0, 32'h1000));
    want.push_back(pk(TT_START, 0, 32'h3000));
    checks++;
    if (obs_q.size() != want.size()) begin errors++; $display("FAIL enable_count: got %0d want %0d", obs_q.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL enable_pkt%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL enable_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 1, 64'h1000, 0);
    step(1, 1, 64'h2000, 0);
    step(1, 1, 64'h3000, 0);
    checks++;
    if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre: valid=%b want 1", trace_valid_o); end
    #2 reset_n_i = 1'b0;
    enable_i = 1'b0; commit_valid_i = 1'b0;
    #1;
    checks++;
    if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", trace_valid_o); end
    checks++;
    if (trace_data_o !== '0) begin errors++; $display("FAIL areset_data: got %h want 0", trace_data_o); end
    @(posedge clk_i); #1 reset_n_i = 1'b1;
    mdl_clear();
    repeat (3) step(1, 0, 64'h0, 1);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL areset_empty: got %0d packets want 0", obs_q.size()); end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL areset_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  task automatic test_random();
    logic [31:0] prev;
    logic [31:0] lo;
    int          sel, bad;
    bit          en, v, rdy;
    do_reset();
    prev = 32'h8000;
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      lo = prev + 32'(STEP_BYTES);
      else if (sel < 8) lo = $urandom() & 32'hFFFF_FFFC;
      else              lo = prev;
      en  = ($urandom_range(0, 19) != 0);
      v   = ($urandom_range(0, 9) < 7);
      rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (v) prev = lo;
      step(en, v, {$urandom(), lo}, rdy);
    end
    repeat (8) step(1, 0, 64'h0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_stream: %0d packets differ, want 0", bad); end
    checks++;
    if (cyc_mis !== 0) begin errors++; $display("FAIL rand_cycle: %0d mismatches, first %s", cyc_mis, mis_msg); end
  endtask

  initial begin
    cycle = 0;
    mdl_clear();
    test_reset();
    test_basic();
    test_sync();
    test_wrap();
    test_overflow();
    test_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
